// File: rtl/dual_negedge_monitor.sv
// Falling-edge monitor for two level signals: flags pairs that fall within WINDOW cycles
// of each other, flags unpaired falls as timeouts, and keeps a saturating pair count.
module dual_negedge_monitor #(
  parameter int WINDOW = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_a,
  input  logic             sig_b,
  output logic             fall_a,
  output logic             fall_b,
  output logic             both_fell,
  output logic             timeout,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [1:0]       state
);

  localparam int TW = $clog2(WINDOW + 1);
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    GOT_B = 2'd2
  } state_t;

  state_t        state_q;
  logic          a_q;
  logic          b_q;
  logic [TW-1:0] timer;
  logic          fa;
  logic          fb;
  logic          pair_ev;

  assign fa = a_q & ~sig_a;
  assign fb = b_q & ~sig_b;

  // The partner fall is checked ahead of the timer, so a fall at d = WINDOW pairs.
  always_comb begin
    pair_ev = 1'b0;
    case (state_q)
      IDLE:    pair_ev = fa & fb;
      GOT_A:   pair_ev = fb;
      GOT_B:   pair_ev = fa;
      default: pair_ev = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= 1'b1;
      b_q       <= 1'b1;
      fall_a    <= 1'b0;
      fall_b    <= 1'b0;
      both_fell <= 1'b0;
      timeout   <= 1'b0;
      pair_cnt  <= '0;
      state_q   <= IDLE;
      timer     <= '0;
    end else begin
      a_q       <= sig_a;
      b_q       <= sig_b;
      fall_a    <= fa;
      fall_b    <= fb;
      both_fell <= pair_ev;
      timeout   <= 1'b0;
      if (pair_ev && (pair_cnt != {CNT_W{1'b1}}))
        pair_cnt <= pair_cnt + 1'b1;

      case (state_q)
        IDLE: begin
          if (fa && !fb) begin
            state_q <= GOT_A;
            timer   <= '0;
          end else if (fb && !fa) begin
            state_q <= GOT_B;
            timer   <= '0;
          end
        end
        GOT_A: begin
          if (fb) begin
            state_q <= IDLE;
          end else if (fa) begin
            timer <= '0;
          end else if (timer == T_LAST) begin
            timeout <= 1'b1;
            state_q <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GOT_B: begin
          if (fa) begin
            state_q <= IDLE;
          end else if (fb) begin
            timer <= '0;
          end else if (timer == T_LAST) begin
            timeout <= 1'b1;
            state_q <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          timer   <= '0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_dual_negedge_monitor.sv
// Directed bench for dual_negedge_monitor (WINDOW = 4, CNT_W = 2); expectations are
// queued as each step is driven and compared one edge later.
module tb_dual_negedge_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_a;
  logic       sig_b;
  logic       fall_a;
  logic       fall_b;
  logic       both_fell;
  logic       timeout;
  logic [1:0] pair_cnt;
  logic [1:0] state;

  dual_negedge_monitor #(.WINDOW(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_a     (sig_a),
    .sig_b     (sig_b),
    .fall_a    (fall_a),
    .fall_b    (fall_b),
    .both_fell (both_fell),
    .timeout   (timeout),
    .pair_cnt  (pair_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fa;
    logic       fb;
    logic       both;
    logic       to;
    logic [1:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t       sb[$];
  int         ntests = 0;
  int         nfail  = 0;
  logic [1:0] ecnt   = 2'd0;

  // Drive one cycle of stimulus, queue what must appear after the next edge, then check it.
  task automatic step(input logic r, input logic a, input logic b,
                      input logic efa, input logic efb, input logic eb, input logic eto,
                      input logic [1:0] est, input string tag);
    exp_t e;
    exp_t obs;
    rst   = r;
    sig_a = a;
    sig_b = b;
    if (r) ecnt = 2'd0;
    else if (eb && ecnt != 2'd3) ecnt = ecnt + 2'd1;
    e = {efa, efb, eb, eto, ecnt, est};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = {fall_a, fall_b, both_fell, timeout, pair_cnt, state};
    ntests++;
    assert (obs === e) else begin
      nfail++;
      $error("FAIL %s: observed fa=%b fb=%b both=%b to=%b cnt=%0d st=%0d, expected fa=%b fb=%b both=%b to=%b cnt=%0d st=%0d",
             tag, obs.fa, obs.fb, obs.both, obs.to, obs.cnt, obs.st,
             e.fa, e.fb, e.both, e.to, e.cnt, e.st);
    end
  endtask

  initial begin
    rst = 1'b1; sig_a = 1'b1; sig_b = 1'b1;
    #1;

    // 1: reset and idle-high
    step(1, 1, 1, 0, 0, 0, 0, 2'd0, "reset");
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0, 0, 2'd0, "idle_high");

    // 2: simultaneous fall
    step(0, 0, 0, 1, 1, 1, 0, 2'd0, "simul_fall");
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, "simul_low_hold");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "simul_rise");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "simul_idle");

    // 3: A first, B at d = WINDOW pairs
    step(0, 0, 1, 1, 0, 0, 0, 2'd1, "a_first");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 2'd1, "a_wait");
    step(0, 0, 0, 0, 1, 1, 0, 2'd0, "b_at_window");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "post_pair_rise");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "post_pair_idle");

    // GOT_B pairs with A one cycle later
    step(0, 1, 0, 0, 1, 0, 0, 2'd2, "b_first");
    step(0, 0, 0, 1, 0, 1, 0, 2'd0, "a_partner");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "post_b_rise");

    // 4: A alone times out, later B alone enters GOT_B and times out
    step(0, 0, 1, 1, 0, 0, 0, 2'd1, "a_alone");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 2'd1, "a_alone_wait");
    step(0, 0, 1, 0, 0, 0, 1, 2'd0, "a_timeout");
    step(0, 0, 1, 0, 0, 0, 0, 2'd0, "after_timeout");
    step(0, 0, 0, 0, 1, 0, 0, 2'd2, "late_b");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 2'd2, "late_b_wait");
    step(0, 0, 0, 0, 0, 0, 1, 2'd0, "b_timeout");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "rise_after_b");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "idle_after_b");

    // Second A fall re-arms the timer
    step(0, 0, 1, 1, 0, 0, 0, 2'd1, "rearm_first");
    step(0, 0, 1, 0, 0, 0, 0, 2'd1, "rearm_t1");
    step(0, 1, 1, 0, 0, 0, 0, 2'd1, "rearm_rise");
    step(0, 0, 1, 1, 0, 0, 0, 2'd1, "rearm_second");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 2'd1, "rearm_wait");
    step(0, 0, 1, 0, 0, 0, 1, 2'd0, "rearm_timeout");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "rearm_idle");

    // 5: reset while GOT_A discards it
    step(0, 0, 1, 1, 0, 0, 0, 2'd1, "pre_rst_a");
    step(0, 0, 1, 0, 0, 0, 0, 2'd1, "pre_rst_wait");
    step(1, 1, 1, 0, 0, 0, 0, 2'd0, "mid_reset");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "post_rst_1");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "post_rst_2");
    step(0, 1, 0, 0, 1, 0, 0, 2'd2, "post_rst_b");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 2'd2, "post_rst_b_wait");
    step(0, 1, 0, 0, 0, 0, 1, 2'd0, "post_rst_b_timeout");
    step(0, 1, 1, 0, 0, 0, 0, 2'd0, "post_rst_idle");

    // Low at release: idle-high history yields a fall on the first edge
    step(1, 0, 1, 0, 0, 0, 0, 2'd0, "rst_low_a");
    step(0, 0, 1, 1, 0, 0, 0, 2'd1, "release_low_a");
    step(0, 1, 1, 0, 0, 0, 0, 2'd1, "release_rise");
    step(1, 1, 1, 0, 0, 0, 0, 2'd0, "rst_again");

    // 6: saturation at 3
    for (int n = 0; n < 5; n++) begin
      step(0, 0, 0, 1, 1, 1, 0, 2'd0, "sat_pair");
      step(0, 1, 1, 0, 0, 0, 0, 2'd0, "sat_rise");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dual_negedge_monitor.md
Name: dual_negedge_monitor

Overview:
Observes two single-bit level signals, sig_a and sig_b, and detects falling edges on each. It reports when both signals fall within a bounded window of each other, and counts those pairs. It is the checking end for the negedge stimulus style used in our bench fixtures: the fixtures drive both lines high, then drop them together, and this block verifies the drop in hardware. It sits beside any unit under test as a synthesizable monitor.

Parameters:
WINDOW, 4, maximum partner delay in cycles, WINDOW >= 1.
CNT_W, 8, width of the pair counter.

Ports:
clk  input  1  single clock, rising-edge active.
rst  input  1  synchronous, active-high reset.
sig_a  input  1  monitored level A, synchronous to clk.
sig_b  input  1  monitored level B, synchronous to clk.
fall_a  output  1  one-cycle pulse: falling edge seen on sig_a.
fall_b  output  1  one-cycle pulse: falling edge seen on sig_b.
both_fell  output  1  one-cycle pulse: A and B fell within WINDOW cycles of each other.
timeout  output  1  one-cycle pulse: one line fell and its partner did not fall in time.
pair_cnt  output  CNT_W  saturating count of both_fell pulses.
state  output  2  FSM state, for debug: 0 = IDLE, 1 = GOT_A, 2 = GOT_B.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values while rst = 1 at a rising edge:
  - a_q = 1, b_q = 1 (idle-high history).
  - fall_a, fall_b, both_fell, timeout = 0.
  - pair_cnt = 0, state = IDLE, timer = 0.
- Reset mid-operation discards any pending GOT_A/GOT_B state. No timeout is emitted.
- Sampling, every edge: a_q <= sig_a and b_q <= sig_b.
  - Internal events: fa = a_q & ~sig_a, fb = b_q & ~sig_b.
  - fall_a <= fa and fall_b <= fb, so the pulse appears one cycle after the first low sample.
- Consequence of the idle-high history: if sig_a is already low when rst deasserts, fa fires at the first edge after release.
- Rising edges and steady levels produce no events.
- FSM, evaluated at the same edge as fa/fb. Let e be the edge at which a GOT_x state is entered.
  - IDLE, fa & fb: both_fell <= 1, stay IDLE.
  - IDLE, fa only: go to GOT_A, timer <= 0.
  - IDLE, fb only: go to GOT_B, timer <= 0.
  - GOT_A, fb: both_fell <= 1, go to IDLE. This holds even if fa is also set that cycle.
  - GOT_A, fa without fb: re-arm, stay in GOT_A, timer <= 0.
  - GOT_A, no event and timer == WINDOW-1: timeout <= 1, go to IDLE.
  - GOT_A, otherwise: timer <= timer + 1.
  - GOT_B mirrors GOT_A with A and B swapped.
  - Encoding 3 is illegal and goes to IDLE with no pulse.
- Window rule: a partner fall at edge e+d pairs for d = 1..WINDOW. If the partner has not fallen by edge e+WINDOW, timeout fires at edge e+WINDOW.
- Simultaneous events: a partner fall at d = WINDOW wins over timeout. both_fell and timeout are never high in the same cycle.
- both_fell, timeout, fall_a and fall_b are all registered and last exactly one cycle.
- Counter: pair_cnt increments by 1 on each both_fell and saturates at 2^CNT_W - 1 (no wrap).
- Timer width is clog2(WINDOW+1) bits.

Test Plan:
1. Reset, then hold sig_a = sig_b = 1 for 10 cycles -> all pulses 0, pair_cnt = 0, state = 0.
2. Drop sig_a and sig_b together at edge k -> fall_a = fall_b = both_fell = 1 for the cycle after edge k only; pair_cnt = 1; state stays 0.
3. WINDOW = 4: drop sig_a at edge k, sig_b at edge k+4 -> state = 1 from k; both_fell at k+4, no timeout; pair_cnt increments.
4. WINDOW = 4: drop sig_a only at edge k -> timeout pulse at edge k+4, state returns to 0. Then drop sig_b at k+6 -> state = 2, no both_fell.
5. Drop sig_a at edge k, assert rst at k+2, then drop sig_b at k+5 after release -> no both_fell, no timeout, pair_cnt = 0, state = 2 after the sig_b fall.
6. CNT_W = 2: produce 5 simultaneous falls -> pair_cnt sequence 1, 2, 3, 3, 3.
